// File: rtl/nw_vc_free_pool_if.sv
// Bundle between the VC allocator / output-port logic and the per-port free-VC pool.
// The master modport is the router side; the slave modport is the pool.
interface nw_vc_free_pool_if #(
  parameter int nv      = 4,
  parameter int buf_len = 4
);
  localparam int vw = (nv > 1) ? $clog2(nv) : 1;
  localparam int cw = $clog2(buf_len + 1);

  logic                pop_free_vc;
  logic [nv-1:0]       alloc_vc;
  logic                flit_sent;
  logic [nv-1:0]       flit_sent_vc;
  logic                flit_sent_tail;
  logic                credit_valid;
  logic [vw-1:0]       credit_vc;
  logic [nv-1:0]       vc_alloc_status;
  logic [nv-1:0]       next_free_vc;
  logic                no_free_vc;
  logic [nv*cw-1:0]    vc_credits;
  logic [2:0]          err;

  modport master (
    output pop_free_vc, alloc_vc, flit_sent, flit_sent_vc, flit_sent_tail,
           credit_valid, credit_vc,
    input  vc_alloc_status, next_free_vc, no_free_vc, vc_credits, err
  );

  modport slave (
    input  pop_free_vc, alloc_vc, flit_sent, flit_sent_vc, flit_sent_tail,
           credit_valid, credit_vc,
    output vc_alloc_status, next_free_vc, no_free_vc, vc_credits, err
  );
endinterface

// File: rtl/nw_vc_free_pool.sv
// Per-output-port downstream VC tracker: FREE/ALLOCATED/DRAINING state and credit count per VC,
// plus either a FIFO of free VC ids (fifo_mode=1) or a lowest-index free pick (fifo_mode=0).
module nw_vc_free_pool #(
  parameter int nv        = 4,
  parameter int buf_len   = 4,
  parameter bit fifo_mode = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  nw_vc_free_pool_if.slave  pool
);
  localparam int vw = (nv > 1) ? $clog2(nv) : 1;
  localparam int cw = $clog2(buf_len + 1);
  localparam int nw = $clog2(nv + 1);
  localparam logic [cw-1:0] full_cnt = cw'(buf_len);

  typedef enum logic [1:0] {
    VC_FREE  = 2'd0,
    VC_ALLOC = 2'd1,
    VC_DRAIN = 2'd2
  } vc_state_e;

  vc_state_e     state_q [nv];
  vc_state_e     state_d [nv];
  logic [cw-1:0] cred_q  [nv];
  logic [cw-1:0] cred_d  [nv];
  logic [vw-1:0] fifo_q  [nv];
  logic [vw-1:0] fifo_d  [nv];
  logic [vw-1:0] head_q, head_d, tail_q, tail_d;
  logic [nw-1:0] cnt_q, cnt_d;
  logic [2:0]    err_q, err_d;
  logic [nv-1:0] rel;
  logic [nv-1:0] status;
  logic [nv-1:0] head_oh;

  function automatic logic [vw-1:0] ptr_inc(input logic [vw-1:0] p);
    return (p == vw'(nv - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    logic          pop_ok;
    logic          send_v;
    logic          cred_v;
    logic          alloc_v;
    logic [vw-1:0] wr;

    state_d = state_q;
    cred_d  = cred_q;
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rel     = '0;
    send_v  = 1'b0;
    cred_v  = 1'b0;
    alloc_v = 1'b0;
    wr      = tail_q;

    pop_ok = fifo_mode && pool.pop_free_vc && (cnt_q != '0);
    if (fifo_mode && pool.pop_free_vc && (cnt_q == '0)) err_d[0] = 1'b1;

    for (int v = 0; v < nv; v++) begin
      send_v  = pool.flit_sent && pool.flit_sent_vc[v];
      cred_v  = pool.credit_valid && (pool.credit_vc == vw'(v));
      alloc_v = fifo_mode ? (pop_ok && (fifo_q[head_q] == vw'(v))) : pool.alloc_vc[v];

      // A send and a credit on the same VC cancel; saturating edges flag an error instead.
      if (send_v && !cred_v) begin
        if (cred_q[v] == '0) err_d[2] = 1'b1;
        else                 cred_d[v] = cred_q[v] - 1'b1;
      end else if (cred_v && !send_v) begin
        if (cred_q[v] == full_cnt) err_d[1] = 1'b1;
        else                       cred_d[v] = cred_q[v] + 1'b1;
      end

      if (send_v && (state_q[v] != VC_ALLOC)) err_d[2] = 1'b1;

      case (state_q[v])
        VC_FREE:  if (alloc_v) state_d[v] = VC_ALLOC;
        VC_ALLOC: begin
          if (alloc_v) err_d[0] = 1'b1;
          if (send_v && pool.flit_sent_tail) state_d[v] = VC_DRAIN;
        end
        VC_DRAIN: begin
          if (alloc_v) err_d[0] = 1'b1;
          if (cred_d[v] == full_cnt) begin
            state_d[v] = VC_FREE;
            rel[v]     = 1'b1;
          end
        end
        default:  state_d[v] = VC_FREE;
      endcase
    end

    // Released VCs enter the FIFO in ascending index order; the pop above saw only the old contents.
    if (fifo_mode) begin
      for (int v = 0; v < nv; v++) begin
        if (rel[v]) begin
          fifo_d[wr] = vw'(v);
          wr         = ptr_inc(wr);
        end
      end
      tail_d = wr;
      head_d = pop_ok ? ptr_inc(head_q) : head_q;
      cnt_d  = cnt_q - nw'(pop_ok) + nw'($countones(rel));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the FIFO storage is reset because its power-up contents (ids 0..nv-1) are functional state.
      for (int v = 0; v < nv; v++) begin
        state_q[v] <= VC_FREE;
        cred_q[v]  <= full_cnt;
        fifo_q[v]  <= vw'(v);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= nw'(nv);
      err_q  <= '0;
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < nv; g++) begin : g_out
    assign status[g]                    = (state_q[g] == VC_FREE);
    assign pool.vc_credits[g*cw +: cw]  = cred_q[g];
  end

  assign head_oh              = (cnt_q == '0) ? '0 : (nv'(1) << fifo_q[head_q]);
  assign pool.vc_alloc_status = status;
  assign pool.next_free_vc    = fifo_mode ? head_oh : (status & (~status + 1'b1));
  assign pool.no_free_vc      = fifo_mode ? (cnt_q == '0) : ~|status;
  assign pool.err             = err_q;

endmodule

// File: doc/nw_vc_free_pool.md
Name: nw_vc_free_pool

Overview:
- Per-output-port tracker of downstream virtual channels. It produces the free-VC view that the VC allocator consumes: a free bitmap for the unrestricted allocator, and next_free_vc/no_free_vc for the FIFO free-pool allocator.
- Marks VCs busy on allocation and counts downstream credits. It returns a VC to the pool only after its tail flit has left and every credit for that VC has come back.
- One instance per router output port, next to the output-port credit logic.

Parameters:
- nv, 4, number of VCs on the output port.
- buf_len, 4, downstream buffer depth per VC; this is the reset credit count.
- fifo_mode, 1. When 1, allocation is by pop_free_vc and free VCs are handed out in FIFO order. When 0, allocation is by the alloc_vc bitmap and next_free_vc is the lowest-index free VC.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pop_free_vc  in  1  fifo_mode=1 only: the head of the free FIFO is allocated this cycle.
- alloc_vc  in  nv  fifo_mode=0 only: bitmap of VCs allocated this cycle.
- flit_sent  in  1  a flit is leaving this port this cycle.
- flit_sent_vc  in  nv  one-hot VC of the departing flit.
- flit_sent_tail  in  1  the departing flit is a tail (or a head-tail flit).
- credit_valid  in  1  downstream returns one credit this cycle.
- credit_vc  in  clogb2(nv)  VC index of the returned credit.
- vc_alloc_status  out  nv  bit v = 1 when VC v is FREE.
- next_free_vc  out  nv  one-hot next VC to allocate; 0 when none is free.
- no_free_vc  out  1  no VC is available to allocate.
- vc_credits  out  nv*clogb2(buf_len+1)  credit count per VC.
- err  out  3  sticky error flags: [0] allocation of a non-free VC or pop on empty; [1] credit overflow; [2] send with no credit or to a VC that is not ALLOCATED.

Behaviour:
- Per-VC state machine: FREE -> ALLOCATED -> DRAINING -> FREE.
  - FREE -> ALLOCATED on allocation.
  - ALLOCATED -> DRAINING when flit_sent & flit_sent_tail for that VC.
  - DRAINING -> FREE when the updated credit count equals buf_len.
  - Tail sent with credits_next already equal to buf_len is impossible, because a send decrements the count; the VC goes to DRAINING.
- Reset, synchronous, active when rst=1 on a clock edge:
  - all VCs FREE;
  - all credits = buf_len;
  - FIFO holds VC ids 0..nv-1 with 0 at the head;
  - err = 0;
  - outputs after the reset edge: vc_alloc_status = all ones, next_free_vc = 1 (VC0), no_free_vc = 0.
  - Reset mid-operation discards all state with no drain.
- Credit counter update, per VC:
  - count_next = count − (send to this VC) + (credit to this VC).
  - A send and a credit to the same VC in the same cycle leave the count unchanged.
  - A send at count 0 holds the count at 0 and sets err[2].
  - A credit at count buf_len holds the count at buf_len and sets err[1].
- All outputs are registered state; every event is visible on the outputs the cycle after it is sampled.
- fifo_mode=1:
  - FIFO depth nv, storing VC indices; next_free_vc = decoded head; no_free_vc = FIFO empty.
  - pop_free_vc while empty is ignored and sets err[0].
  - Push and pop in the same cycle are both performed.
  - Several VCs releasing in the same cycle are pushed in ascending index order. The FIFO cannot overflow because it holds only nv distinct ids.
  - A VC released this cycle is not poppable until the next cycle.
  - alloc_vc is ignored.
- fifo_mode=0:
  - next_free_vc = lowest-index FREE VC; no_free_vc = ~|vc_alloc_status.
  - Setting alloc_vc for a VC that is not FREE leaves that VC unchanged and sets err[0]; other bits in the same bitmap proceed normally.
  - pop_free_vc is ignored.
- A send to a VC that is not ALLOCATED sets err[2]. The credit count still updates; the state does not change.
- Flits sent to a DRAINING VC are illegal and also set err[2].
- Error bits clear only on reset.

Test Plan (nv=4, buf_len=4):
- Reset, fifo_mode=1 -> vc_alloc_status=4'b1111, next_free_vc=4'b0001, vc_credits all 4, err=0.
- Four consecutive pops -> next_free_vc steps 0001, 0010, 0100, 1000, then 0000 with no_free_vc=1. A fifth pop sets err[0] and changes no other state.
- Allocate VC0; send 3 flits on VC0, the third a tail -> VC0 credits=1, state DRAINING, status bit 0 = 0.
  - Return 3 credits -> on the cycle after the third credit, credits=4, vc_alloc_status[0]=1, and VC0 id is at the FIFO tail.
- Same-cycle send and credit on VC1 at credits=2 -> credits stay 2. A credit on VC2 at credits=4 -> credits stay 4, err[1]=1.
- Release VC3 and VC1 in the same cycle with the FIFO empty -> FIFO order 1 then 3. A same-cycle pop does not return either VC; no_free_vc=1 for that cycle.
- fifo_mode=0: alloc_vc=4'b0101 -> next_free_vc=4'b0010. alloc_vc=4'b0001 again -> err[0]=1 and VC0 is unchanged. Assert rst mid-drain -> full reset state restored on the next edge.
